audio_buf_ctrl: RTL and testbench

//  Consumer of the key-detect controls (record_en, play_en, sdr_waddr_set,
//  sdr_raddr_set). Turns codec ADC sample strobes into SDRAM write requests

---
 rtl/audio_buf_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_audio_buf_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_buf_ctrl.sv
// audio_buf_ctrl
//   Bridges the codec sample strobes and the SDRAM controller port.
//   While recording, each ADC sample is queued as one SDRAM write at the
//   next free address. While playing, each DAC request becomes one SDRAM
//   read. Playback stops at the last recorded sample. Only one SDRAM
//   transaction is outstanding at a time, and writes win over reads.
//
// Ports
//   clk50M, reset_n              clock (rising edge), synchronous active-low reset
//   record_en, play_en           level enables from key detect
//   sdr_waddr_set, sdr_raddr_set level: hold write / read side at address 0
//   adc_valid, adc_data          ADC sample strobe and data
//   dac_req                      DAC asks for its next sample
//   wr_req, wr_addr, wr_data     SDRAM write request, held until wr_ack
//   wr_ack                       SDRAM write accept
//   rd_req, rd_addr              SDRAM read request, held until rd_ack
//   rd_ack, rd_data              SDRAM read completion and data
//   dac_data, dac_valid          playback sample and its update strobe
//   rec_len                      number of samples recorded
//   full, play_done, xrun        sticky status flags
module audio_buf_ctrl #(
  parameter int                ADDR_W   = 22,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              clk50M,
  input  logic              reset_n,
  input  logic              record_en,
  input  logic              play_en,
  input  logic              sdr_waddr_set,
  input  logic              sdr_raddr_set,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              dac_req,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ack,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  output logic [ADDR_W-1:0] rec_len,
  output logic              full,
  output logic              play_done,
  output logic              xrun
);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] wr_hold;
  logic              wr_pend;
  logic              rd_pend;
  // Set while the in-flight transaction was orphaned by an address reset:
  // it still completes on the bus but must not touch pointers or outputs.
  logic              wr_ign;
  logic              rd_ign;

  logic              cap_hit;
  logic              play_hit;

  assign cap_hit  = adc_valid & record_en & ~full & ~sdr_waddr_set;
  assign play_hit = dac_req & play_en & ~sdr_raddr_set;

  // Write pointer advance that sticks at the last writable address.
  function automatic logic [ADDR_W-1:0] waddr_next(input logic [ADDR_W-1:0] a);
    return (a == MAX_ADDR) ? a : a + 1'b1;
  endfunction

  always_ff @(posedge clk50M) begin
    if (!reset_n) begin
      state     <= IDLE;
      waddr     <= '0;
      raddr     <= '0;
      wr_hold   <= '0;
      wr_pend   <= 1'b0;
      rd_pend   <= 1'b0;
      wr_ign    <= 1'b0;
      rd_ign    <= 1'b0;
      wr_req    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      dac_data  <= '0;
      dac_valid <= 1'b0;
      rec_len   <= '0;
      full      <= 1'b0;
      play_done <= 1'b0;
      xrun      <= 1'b0;
    end else begin
      dac_valid <= 1'b0;

      // Sample capture: a second sample before the first is written is lost.
      if (cap_hit) begin
        if (wr_pend) begin
          xrun <= 1'b1;
        end else begin
          wr_hold <= adc_data;
          wr_pend <= 1'b1;
        end
      end

      // Playback request: at the end of the recording answer with silence.
      if (play_hit) begin
        if (rd_pend) begin
          xrun <= 1'b1;
        end else if (raddr == rec_len) begin
          dac_data  <= '0;
          dac_valid <= 1'b1;
          play_done <= 1'b1;
        end else begin
          rd_pend <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (wr_pend && !sdr_waddr_set) begin
            state   <= WR;
            wr_req  <= 1'b1;
            wr_addr <= waddr;
            wr_data <= wr_hold;
          end else if (rd_pend && !sdr_raddr_set) begin
            state   <= RD;
            rd_req  <= 1'b1;
            rd_addr <= raddr;
          end
        end
        WR: begin
          if (wr_ack) begin
            state  <= IDLE;
            wr_req <= 1'b0;
            wr_ign <= 1'b0;
            if (!wr_ign) begin
              wr_pend <= 1'b0;
              // rec_len wraps to 0 only when the whole address space is used.
              rec_len <= waddr + 1'b1;
              waddr   <= waddr_next(waddr);
              if (waddr == MAX_ADDR) full <= 1'b1;
            end
          end
        end
        RD: begin
          if (rd_ack) begin
            state  <= IDLE;
            rd_req <= 1'b0;
            rd_ign <= 1'b0;
            if (!rd_ign) begin
              rd_pend   <= 1'b0;
              dac_data  <= rd_data;
              dac_valid <= 1'b1;
              raddr     <= raddr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Address resets override everything above in the same cycle.
      if (sdr_waddr_set) begin
        waddr   <= '0;
        rec_len <= '0;
        full    <= 1'b0;
        wr_pend <= 1'b0;
        xrun    <= 1'b0;
        if (state == WR && !wr_ack) wr_ign <= 1'b1;
      end
      if (sdr_raddr_set) begin
        raddr     <= '0;
        play_done <= 1'b0;
        rd_pend   <= 1'b0;
        xrun      <= 1'b0;
        dac_valid <= 1'b0;
        if (state == RD && !rd_ack) rd_ign <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_buf_ctrl.sv
module tb_audio_buf_ctrl;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 16;

  logic              clk50M = 1'b0;
  logic              reset_n;
  logic              record_en, play_en, sdr_waddr_set, sdr_raddr_set;
  logic              adc_valid, dac_req;
  logic [DATA_W-1:0] adc_data;
  logic              wr_req, rd_req, wr_ack, rd_ack;
  logic [ADDR_W-1:0] wr_addr, rd_addr, rec_len;
  logic [DATA_W-1:0] wr_data, rd_data, dac_data;
  logic              dac_valid, full, play_done, xrun;

  always #10 clk50M = ~clk50M;

  audio_buf_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_ADDR(22'd3)) dut (
    .clk50M(clk50M), .reset_n(reset_n), .record_en(record_en), .play_en(play_en),
    .sdr_waddr_set(sdr_waddr_set), .sdr_raddr_set(sdr_raddr_set),
    .adc_valid(adc_valid), .adc_data(adc_data), .dac_req(dac_req),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .dac_data(dac_data), .dac_valid(dac_valid), .rec_len(rec_len),
    .full(full), .play_done(play_done), .xrun(xrun)
  );

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_exp_t;

  wr_exp_t           wr_q[$];
  logic [DATA_W-1:0] dac_q[$];

  int errs = 0;
  int checks = 0;
  int wr_cnt = 0;
  int dac_cnt = 0;
  int cyc = 0;
  int wr_ack_cyc = 0;
  logic ack_en = 1'b1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk50M) cyc <= cyc + 1;

  // SDRAM model: acks 2 cycles after a request; reads return addr + 0xA000.
  // Also the output monitor for write contents and DAC samples.
  initial begin
    int wc, rc;
    wr_exp_t e;
    logic [DATA_W-1:0] de;
    wc = 0; rc = 0;
    wr_ack = 1'b0; rd_ack = 1'b0; rd_data = '0;
    forever begin
      @(negedge clk50M);
      wr_ack = 1'b0;
      rd_ack = 1'b0;
      if (reset_n !== 1'b1 || wr_req !== 1'b1) wc = 0;
      else if (ack_en) begin
        wc++;
        if (wc == 2) begin
          wr_ack = 1'b1; wc = 0; wr_cnt++; wr_ack_cyc = cyc;
          if (wr_q.size() == 0) chk("wr_unexpected", 32'(wr_addr), 32'hFFFF_FFFF);
          else begin
            e = wr_q.pop_front();
            chk("wr_addr", 32'(wr_addr), 32'(e.a));
            chk("wr_data", 32'(wr_data), 32'(e.d));
          end
        end
      end
      if (reset_n !== 1'b1 || rd_req !== 1'b1) rc = 0;
      else begin
        rc++;
        if (rc == 2) begin
          rd_ack = 1'b1; rc = 0;
          rd_data = rd_addr[DATA_W-1:0] + 16'hA000;
        end
      end
      if (reset_n === 1'b1 && dac_valid === 1'b1) begin
        dac_cnt++;
        if (dac_q.size() == 0) chk("dac_unexpected", 32'(dac_data), 32'hFFFF_FFFF);
        else begin
          de = dac_q.pop_front();
          chk("dac_data", 32'(dac_data), 32'(de));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk50M);
  endtask

  task automatic adc(input logic [DATA_W-1:0] d);
    adc_valid = 1'b1; adc_data = d;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic dac();
    dac_req = 1'b1;
    tick();
    dac_req = 1'b0;
  endtask

  task automatic wait_wr(input int n);
    for (int k = 0; k < 60 && wr_cnt < n; k++) tick();
    chk("wr_cnt", 32'(wr_cnt), 32'(n));
    tick(3);
  endtask

  task automatic wait_dac(input int n);
    for (int k = 0; k < 60 && dac_cnt < n; k++) tick();
    chk("dac_cnt", 32'(dac_cnt), 32'(n));
    tick(2);
  endtask

  task automatic pulse_set(input logic w, input logic r);
    sdr_waddr_set = w; sdr_raddr_set = r;
    tick();
    sdr_waddr_set = 1'b0; sdr_raddr_set = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int wr_first, rd_first;
    reset_n = 1'b0; record_en = 1'b0; play_en = 1'b0;
    sdr_waddr_set = 1'b0; sdr_raddr_set = 1'b0;
    adc_valid = 1'b0; adc_data = '0; dac_req = 1'b0;
    tick(3);
    chk("rst_wr_req", 32'(wr_req), 0);
    chk("rst_rd_req", 32'(rd_req), 0);
    chk("rst_dac_valid", 32'(dac_valid), 0);
    chk("rst_rec_len", 32'(rec_len), 0);
    chk("rst_flags", {29'd0, full, play_done, xrun}, 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    reset_n = 1'b1;
    tick();

    // Record four samples at addresses 0..3
    record_en = 1'b1;
    pulse_set(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wr_q.push_back('{ADDR_W'(i), DATA_W'(16'h1111 * (i + 1))});
      adc(DATA_W'(16'h1111 * (i + 1)));
      wait_wr(i + 1);
    end
    chk("rec_len_4", 32'(rec_len), 4);
    chk("full_at_max", 32'(full), 1);

    // Play back: four recorded samples then silence with play_done
    play_en = 1'b1;
    pulse_set(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      dac_q.push_back(i < 4 ? DATA_W'(16'hA000 + i) : 16'h0000);
      dac();
      wait_dac(i + 1);
    end
    chk("play_done", 32'(play_done), 1);
    chk("xrun_clean", 32'(xrun), 0);

    // Fill to MAX_ADDR; further samples are ignored
    pulse_set(1'b1, 1'b0);
    chk("full_cleared", 32'(full), 0);
    chk("rec_len_cleared", 32'(rec_len), 0);
    base = wr_cnt;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        wr_q.push_back('{ADDR_W'(i), DATA_W'(16'h0100 + i)});
        adc(DATA_W'(16'h0100 + i));
        wait_wr(base + i + 1);
      end else begin
        adc(DATA_W'(16'h0100 + i));
        tick(8);
        chk("no_wr_req_full", 32'(wr_req), 0);
      end
    end
    chk("full_wr_cnt", 32'(wr_cnt), 32'(base + 4));
    chk("full_set", 32'(full), 1);
    chk("full_rec_len", 32'(rec_len), 4);
    chk("full_no_xrun", 32'(xrun), 0);

    // Overrun: second sample while the first waits for its ack
    pulse_set(1'b1, 1'b0);
    ack_en = 1'b0;
    base = wr_cnt;
    wr_q.push_back('{ADDR_W'(0), 16'h5555});
    adc(16'h5555);
    adc(16'h6666);
    tick(4);
    chk("xrun_set", 32'(xrun), 1);
    chk("wr_req_held", 32'(wr_req), 1);
    chk("wr_data_held", 32'(wr_data), 32'h5555);
    ack_en = 1'b1;
    wait_wr(base + 1);
    tick(10);
    chk("xrun_one_write", 32'(wr_cnt), 32'(base + 1));
    chk("xrun_rec_len", 32'(rec_len), 1);

    // Same-cycle sample and request: write goes first
    pulse_set(1'b1, 1'b1);
    chk("xrun_cleared", 32'(xrun), 0);
    base = wr_cnt;
    wr_q.push_back('{ADDR_W'(0), 16'h7777});
    adc(16'h7777);
    wait_wr(base + 1);
    wr_q.push_back('{ADDR_W'(1), 16'h8888});
    dac_q.push_back(16'hA000);
    base = dac_cnt;
    adc_valid = 1'b1; adc_data = 16'h8888; dac_req = 1'b1;
    tick();
    adc_valid = 1'b0; dac_req = 1'b0;
    wr_first = 0; rd_first = 0;
    for (int k = 0; k < 30; k++) begin
      if (wr_req && wr_first == 0) wr_first = cyc;
      if (rd_req && rd_first == 0) rd_first = cyc;
      tick();
    end
    chk("wr_before_rd", 32'(wr_first != 0 && wr_first < rd_first), 1);
    chk("rd_after_wr_ack", 32'(rd_first > wr_ack_cyc), 1);
    wait_dac(base + 1);
    chk("both_rec_len", 32'(rec_len), 2);

    // Reset while a write request is outstanding
    ack_en = 1'b0;
    base = wr_cnt;
    adc(16'h9999);
    for (int k = 0; k < 20 && wr_req !== 1'b1; k++) tick();
    chk("wr_req_before_rst", 32'(wr_req), 1);
    reset_n = 1'b0;
    tick();
    chk("rst_mid_wr_req", 32'(wr_req), 0);
    chk("rst_mid_rd_req", 32'(rd_req), 0);
    chk("rst_mid_rec_len", 32'(rec_len), 0);
    chk("rst_mid_addr_data", {10'd0, wr_addr} | {16'd0, wr_data}, 0);
    chk("rst_mid_flags", {28'd0, full, play_done, xrun, dac_valid}, 0);
    reset_n = 1'b1;
    ack_en = 1'b1;
    tick(10);
    chk("rst_no_write", 32'(wr_cnt), 32'(base));
    chk("rst_idle_wr_req", 32'(wr_req), 0);

    chk("wr_q_left", 32'(wr_q.size()), 0);
    chk("dac_q_left", 32'(dac_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
